hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage pipelined CPU. It drives the PC/IF_ID enables, the ID-stage control bubble mux, the pipeline-register flushes and the EX-stage operand forwarding selects. It also runs a halt/drain state machine so the testbench or a debug host can quiesce the pipeline. It sits beside the datapath and takes only register numbers and control bits from the IF_ID, ID_EX, EX_MEM and MEM_WB registers, plus the MEM-stage branch decision.

## Interface
- DRAIN_CYCLES, 4: cycles spent in DRAIN before `halted` asserts; range 1–15.
- CNT_W, 32: width of the performance counters; used only with HAZARD_PERFCNT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- id_rn, id_rm  in  5 each  ID-stage source registers; id_rm is the Reg2Loc-mux output
- id_use_rn, id_use_rm  in  1 each  ID instruction actually reads that operand
- ex_rn, ex_rm  in  5 each  ID_EX Rn/Rm fields
- ex_rd  in  5  ID_EX destination
- ex_memread  in  1  ID_EX MemRead
- mem_rd  in  5  EX_MEM destination
- mem_regwrite  in  1  EX_MEM RegWrite
- wb_rd  in  5  MEM_WB destination
- wb_regwrite  in  1  MEM_WB RegWrite
- branch_taken  in  1  MEM-stage taken decision (CBZ/B.LT/B)
- halt_req  in  1  level request to halt fetch and drain
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF_ID load enable
- id_bubble  out  1  select zero control word into ID_EX
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear of that register's control and valid fields at the next edge
- fwd_a, fwd_b  out  2 each  ALU A/B source: 00 = register file, 10 = EX_MEM result, 01 = MEM_WB write data
- halted  out  1  pipeline empty and frozen
- stall_cnt, flush_cnt  out  CNT_W each  performance counters (HAZARD_PERFCNT_EN only)

## Operation
- States: RUN, DRAIN, HALTED. Register 31 (XZR) never produces a hazard or a forward.
- **Load-use hazard:** `lu` = ex_memread & ex_rd≠31 & ((id_use_rn & ex_rd==id_rn) | (id_use_rm & ex_rd==id_rm)).
- **Forwarding (fwd_a from ex_rn; fwd_b from ex_rm, identical logic):**
  - 10 if mem_regwrite & mem_rd≠31 & mem_rd==ex_rn;
  - else 01 if wb_regwrite & wb_rd≠31 & wb_rd==ex_rn;
  - else 00. EX_MEM has priority.
- **RUN:** pc_en = ifid_en = 1 and id_bubble = 0, except:
  - branch_taken: pc_en = 1, ifid_flush = idex_flush = exmem_flush = 1; `lu` is ignored.
  - lu (no branch): pc_en = 0, ifid_en = 0, id_bubble = 1.
  - halt_req (no branch): go to DRAIN; pc_en = 0, ifid_flush = 1. The drain counter loads DRAIN_CYCLES.
- **DRAIN:**
  - pc_en = 0, ifid_en = 0, id_bubble = 1.
  - Counter decrements each cycle; at 1 → HALTED.
  - branch_taken in DRAIN: assert all three flushes and reload the counter. pc_en = 1 for that cycle only, so the target is captured and fetched on resume.
  - halt_req dropping in DRAIN: return to RUN next cycle.
- **HALTED:** halted = 1, pc_en = 0, ifid_en = 0, id_bubble = 1. When halt_req = 0 → RUN next cycle.
- Simultaneous branch_taken & lu & halt_req in RUN: flush wins; the state still moves to DRAIN.

## Timing
- Every output except halted and the counters is combinational from the inputs and the current state; no added latency.
- State, the drain counter, halted and the counters update on the rising clk edge.
- While rst = 0, outputs take their reset values:
  - state = RUN;
  - halted = 0;
  - pc_en = ifid_en = 0;
  - id_bubble = 1;
  - all flushes = 0;
  - fwd_a = fwd_b = 00;
  - counters = 0.
- Deasserting rst takes effect at the next edge.
- Reset asserted in the middle of DRAIN aborts the drain with no halted pulse.
- A load-use stall lasts exactly one cycle: the load moves to EX_MEM and ex_memread clears.
- halted rises DRAIN_CYCLES edges after the edge that entered DRAIN.

## Configuration
- **HAZARD_PERFCNT_EN defined:**
  - stall_cnt increments on each cycle `lu` stalls in RUN.
  - flush_cnt increments on each cycle branch_taken flushes.
  - Both saturate at all-ones.
- **Not defined:** the counter ports are absent and no counter flops are built.

## Test plan
- **Load-use stall:** ex_memread = 1, ex_rd = 3, id_rn = 3, id_use_rn = 1 → pc_en = 0, ifid_en = 0, id_bubble = 1 for one cycle. With ex_rd = 31, no stall.
- **Forwarding priority:** mem_rd = wb_rd = ex_rm = 5, both regwrites = 1 → fwd_b = 10. Clear mem_regwrite → fwd_b = 01.
- **Branch over stall:** branch_taken = 1 while `lu` is true → all three flushes = 1, pc_en = 1, id_bubble = 0. flush_cnt increments by 1 when enabled.
- **Halt/resume:** halt_req = 1 in RUN → halted = 1 after 4 edges (default). Drop halt_req → RUN with pc_en = 1 next cycle.
- **Branch during DRAIN:** branch_taken on drain cycle 2 → flushes asserted and halted delayed to 4 edges after the branch.
- **Async reset:** rst = 0 mid-DRAIN, between clock edges → state RUN, halted = 0, outputs at reset values immediately.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: datapath register numbers and control bits in,
// pipeline enables/flushes/forward selects out.
// Optional feature macro: HAZARD_PERFCNT_EN adds the stall/flush counters.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rn, id_rm;
  logic             id_use_rn, id_use_rm;
  logic [4:0]       ex_rn, ex_rm, ex_rd;
  logic             ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             branch_taken;
  logic             halt_req;
  logic             pc_en, ifid_en, id_bubble;
  logic             ifid_flush, idex_flush, exmem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             halted;
`ifdef HAZARD_PERFCNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  // Side that drives the datapath fields and observes the controls.
  modport master (
    output id_rn, id_rm, id_use_rn, id_use_rm, ex_rn, ex_rm, ex_rd, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken, halt_req,
    input  pc_en, ifid_en, id_bubble, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, halted
`ifdef HAZARD_PERFCNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  // The hazard controller itself.
  modport slave (
    input  id_rn, id_rm, id_use_rn, id_use_rm, ex_rn, ex_rm, ex_rd, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken, halt_req,
    output pc_en, ifid_en, id_bubble, ifid_flush, idex_flush, exmem_flush,
           fwd_a, fwd_b, halted
`ifdef HAZARD_PERFCNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush,
// EX-stage forwarding and a halt/drain sequencer.
// Optional feature macro: HAZARD_PERFCNT_EN builds saturating stall/flush
// counters (width taken from the interface CNT_W).
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,     // asynchronous, active-low
  hazard_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [4:0] XZR        = 5'd31;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t     state_reg;
  logic [3:0] drain_cnt_reg;
  logic       halted_reg;
  // Cleared by reset, set at the first edge after release: holds every
  // output at its reset value until that edge.
  logic       active_reg;

  logic       lu;
  logic       pc_en, ifid_en, id_bubble;
  logic       ifid_flush, idex_flush, exmem_flush;
  logic       lu_stall, br_flush;
  logic [1:0] fwd_a, fwd_b;

  // EX_MEM beats MEM_WB; XZR never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we, input logic [4:0] wb_rd);
    if (mem_we && mem_rd != XZR && mem_rd == src)
      return 2'b10;
    else if (wb_we && wb_rd != XZR && wb_rd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign lu = bus.ex_memread && bus.ex_rd != XZR &&
              ((bus.id_use_rn && bus.ex_rd == bus.id_rn) ||
               (bus.id_use_rm && bus.ex_rd == bus.id_rm));

  // Combinational pipeline controls from the current state and inputs.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    id_bubble   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    lu_stall    = 1'b0;
    br_flush    = 1'b0;
    if (active_reg) begin
      fwd_a = fwd_sel(bus.ex_rn, bus.mem_regwrite, bus.mem_rd, bus.wb_regwrite, bus.wb_rd);
      fwd_b = fwd_sel(bus.ex_rm, bus.mem_regwrite, bus.mem_rd, bus.wb_regwrite, bus.wb_rd);
      case (state_reg)
        RUN: begin
          pc_en     = 1'b1;
          ifid_en   = 1'b1;
          id_bubble = 1'b0;
          if (bus.branch_taken) begin
            // Flush dominates both the stall and the halt request.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            br_flush    = 1'b1;
          end else begin
            if (lu) begin
              pc_en     = 1'b0;
              ifid_en   = 1'b0;
              id_bubble = 1'b1;
              lu_stall  = 1'b1;
            end
            if (bus.halt_req) begin
              pc_en      = 1'b0;
              ifid_flush = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.branch_taken) begin
            // Let the branch target into the PC so fetch resumes there.
            pc_en       = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            br_flush    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Halt/drain sequencer with registered halted flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      drain_cnt_reg <= 4'd0;
      halted_reg    <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      active_reg <= 1'b1;
      if (active_reg) begin
        case (state_reg)
          RUN: begin
            if (bus.halt_req) begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= DRAIN_LOAD;
            end
          end
          DRAIN: begin
            if (!bus.halt_req) begin
              state_reg <= RUN;
            end else if (bus.branch_taken) begin
              drain_cnt_reg <= DRAIN_LOAD;
            end else if (drain_cnt_reg <= 4'd1) begin
              state_reg  <= HALTED;
              halted_reg <= 1'b1;
            end else begin
              drain_cnt_reg <= drain_cnt_reg - 4'd1;
            end
          end
          HALTED: begin
            if (!bus.halt_req) begin
              state_reg  <= RUN;
              halted_reg <= 1'b0;
            end
          end
          default: begin
            state_reg  <= RUN;
            halted_reg <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef HAZARD_PERFCNT_EN
  logic [$bits(bus.stall_cnt)-1:0] stall_cnt_reg;
  logic [$bits(bus.flush_cnt)-1:0] flush_cnt_reg;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (lu_stall && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (br_flush && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;
`endif

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.id_bubble   = id_bubble;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.halted      = halted_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, scoreboarded bench for hazard_ctrl. Output word compared per step:
// {pc_en, ifid_en, id_bubble, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b, halted}
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  hazard_ctrl_if #(.CNT_W(32)) hif ();

  hazard_ctrl #(.DRAIN_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [10:0] val;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [10:0] RSTV   = 11'b0_0_1_000_00_00_0; // also stall/drain
  localparam logic [10:0] RUNV   = 11'b1_1_0_000_00_00_0;
  localparam logic [10:0] HALTV  = 11'b0_0_1_000_00_00_1;
  localparam logic [10:0] BRV    = 11'b1_1_0_111_00_00_0;
  localparam logic [10:0] HENTV  = 11'b0_1_0_100_00_00_0;
  localparam logic [10:0] DRBRV  = 11'b1_0_1_111_00_00_0;
  localparam logic [10:0] FB10V  = 11'b1_1_0_000_00_10_0;
  localparam logic [10:0] FB01V  = 11'b1_1_0_000_00_01_0;
  localparam logic [10:0] FA10V  = 11'b1_1_0_000_10_00_0;

  function automatic logic [10:0] observed();
    return {hif.pc_en, hif.ifid_en, hif.id_bubble, hif.ifid_flush, hif.idex_flush,
            hif.exmem_flush, hif.fwd_a, hif.fwd_b, hif.halted};
  endfunction

  // Pop the oldest expectation and compare it with the DUT outputs now.
  task automatic check_now();
    exp_t e;
    logic [10:0] obs;
    e   = q.pop_front();
    obs = observed();
    n_checks++;
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
    $display("step %-14s observed=%b expected=%b", e.tag, obs, e.val);
  endtask

  // Queue an expectation for the current inputs, sample at the falling edge,
  // then advance past the next rising edge.
  task automatic step(input string tag, input logic [10:0] val);
    q.push_back('{tag, val});
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERFCNT_EN
  task automatic check_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    $display("count %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask
`endif

  task automatic idle();
    hif.id_rn = 5'd0;  hif.id_rm = 5'd0;
    hif.id_use_rn = 1'b0;  hif.id_use_rm = 1'b0;
    hif.ex_rn = 5'd0;  hif.ex_rm = 5'd0;  hif.ex_rd = 5'd0;
    hif.ex_memread = 1'b0;
    hif.mem_rd = 5'd0;  hif.mem_regwrite = 1'b0;
    hif.wb_rd = 5'd0;   hif.wb_regwrite = 1'b0;
    hif.branch_taken = 1'b0;
    hif.halt_req = 1'b0;
  endtask

  task automatic load_use_rn3();
    hif.ex_memread = 1'b1; hif.ex_rd = 5'd3; hif.id_rn = 5'd3; hif.id_use_rn = 1'b1;
  endtask

  initial begin
    idle();
    // Reset and release: outputs held until the edge after release.
    step("reset", RSTV);
    rst = 1'b1;
    step("rst_release", RSTV);
    step("run_idle", RUNV);

    // Load-use stalls and their non-stall variants.
    load_use_rn3();
    step("lu_rn", RSTV);
    idle(); hif.mem_rd = 5'd3; hif.mem_regwrite = 1'b1;
    step("lu_clear", RUNV);
    idle(); hif.ex_memread = 1'b1; hif.ex_rd = 5'd31; hif.id_rn = 5'd31; hif.id_use_rn = 1'b1;
    step("lu_xzr", RUNV);
    idle(); hif.ex_memread = 1'b1; hif.ex_rd = 5'd7; hif.id_rm = 5'd7; hif.id_use_rm = 1'b1;
    step("lu_rm", RSTV);
    hif.id_use_rm = 1'b0; hif.id_use_rn = 1'b1;
    step("lu_rm_unused", RUNV);

    // Forwarding priority and XZR suppression.
    idle(); hif.ex_rm = 5'd5; hif.mem_rd = 5'd5; hif.wb_rd = 5'd5;
    hif.mem_regwrite = 1'b1; hif.wb_regwrite = 1'b1;
    step("fwd_b_mem", FB10V);
    hif.mem_regwrite = 1'b0;
    step("fwd_b_wb", FB01V);
    idle(); hif.ex_rn = 5'd9; hif.mem_rd = 5'd9; hif.wb_rd = 5'd9;
    hif.mem_regwrite = 1'b1; hif.wb_regwrite = 1'b1;
    step("fwd_a_mem", FA10V);
    idle(); hif.ex_rn = 5'd31; hif.ex_rm = 5'd31; hif.mem_rd = 5'd31; hif.wb_rd = 5'd31;
    hif.mem_regwrite = 1'b1; hif.wb_regwrite = 1'b1;
    step("fwd_xzr", RUNV);

    // Branch wins over a load-use stall.
    idle(); load_use_rn3(); hif.branch_taken = 1'b1;
    step("br_over_lu", BRV);
`ifdef HAZARD_PERFCNT_EN
    check_cnt("stall_cnt_a", hif.stall_cnt, 32'd2);
    check_cnt("flush_cnt_a", hif.flush_cnt, 32'd1);
`endif

    // Halt, drain four edges, resume.
    idle(); hif.halt_req = 1'b1;
    step("halt_enter", HENTV);
    step("drain1", RSTV);
    step("drain2", RSTV);
    step("drain3", RSTV);
    step("drain4", RSTV);
    step("halted", HALTV);
    step("halted_hold", HALTV);
    hif.halt_req = 1'b0;
    step("resume_req", HALTV);
    step("resumed", RUNV);

    // Branch on drain cycle 2 reloads the drain counter.
    hif.halt_req = 1'b1;
    step("halt_enter2", HENTV);
    step("drain1b", RSTV);
    hif.branch_taken = 1'b1;
    step("drain_br", DRBRV);
    hif.branch_taken = 1'b0;
    step("drain_br1", RSTV);
    step("drain_br2", RSTV);
    step("drain_br3", RSTV);
    step("drain_br4", RSTV);
    step("halted2", HALTV);
`ifdef HAZARD_PERFCNT_EN
    check_cnt("flush_cnt_b", hif.flush_cnt, 32'd2);
`endif
    hif.halt_req = 1'b0;
    step("resume_req2", HALTV);
    step("resumed2", RUNV);

    // Branch + load-use + halt together: flush, but still enter DRAIN.
    load_use_rn3(); hif.branch_taken = 1'b1; hif.halt_req = 1'b1;
    step("triple", BRV);
    idle(); hif.halt_req = 1'b1;
    step("triple_drain", RSTV);
    hif.halt_req = 1'b0;
    step("drain_abort", RSTV);
    step("run_after_abort", RUNV);
`ifdef HAZARD_PERFCNT_EN
    check_cnt("stall_cnt_c", hif.stall_cnt, 32'd2);
    check_cnt("flush_cnt_c", hif.flush_cnt, 32'd3);
`endif

    // Asynchronous reset between edges in the middle of a drain.
    hif.halt_req = 1'b1;
    step("halt_enter3", HENTV);
    step("drain1c", RSTV);
    #2;
    rst = 1'b0;
    #1;
    q.push_back('{"async_rst", RSTV});
    check_now();
`ifdef HAZARD_PERFCNT_EN
    check_cnt("stall_cnt_rst", hif.stall_cnt, 32'd0);
    check_cnt("flush_cnt_rst", hif.flush_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    step("rst_hold1", RSTV);
    step("rst_hold2", RSTV);
    step("rst_hold3", RSTV);
    step("rst_hold4", RSTV);
    hif.halt_req = 1'b0;
    rst = 1'b1;
    step("rst_release2", RSTV);
    step("run_final", RUNV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
